// File: rtl/mfi_pkg.sv
// Shared types and widths for the MFI retire emitter slice.
package mfi_pkg;

    localparam int ORDER_W = 64;
    localparam int INSN_W  = 32;
    localparam int XLEN    = 32;

    typedef struct packed {
        logic [ORDER_W-1:0] order;
        logic [INSN_W-1:0]  insn;
        logic [XLEN-1:0]    pc_rdata;
        logic [XLEN-1:0]    pc_wdata;
        logic               trap;
        logic               halt;
    } mfi_packet_t;

    // Assemble one packet from a retire slot and its assigned sequence number.
    function automatic mfi_packet_t mk_packet(
        input logic [ORDER_W-1:0] order,
        input logic [INSN_W-1:0]  insn,
        input logic [XLEN-1:0]    pc,
        input logic [XLEN-1:0]    next_pc,
        input logic               trap,
        input logic               halt
    );
        mfi_packet_t p;
        p.order    = order;
        p.insn     = insn;
        p.pc_rdata = pc;
        p.pc_wdata = next_pc;
        p.trap     = trap;
        p.halt     = halt;
        return p;
    endfunction

endpackage

// File: rtl/mfi_retire_emitter_if.sv
// Retire-side handshake plus MFI packet port, bundled as one interface.
// slave = the emitter, master = whatever drives retirement and watches MFI.
interface mfi_retire_emitter_if;
    import mfi_pkg::*;

    logic [1:0]          ret_valid;
    logic [2*INSN_W-1:0] ret_insn;
    logic [2*XLEN-1:0]   ret_pc;
    logic [2*XLEN-1:0]   ret_next_pc;
    logic [1:0]          ret_trap;
    logic [1:0]          ret_halt;
    logic                ret_ready;

    logic                mfi_valid;
    logic [ORDER_W-1:0]  mfi_order;
    logic [INSN_W-1:0]   mfi_insn;
    logic [XLEN-1:0]     mfi_pc_rdata;
    logic [XLEN-1:0]     mfi_pc_wdata;
    logic                mfi_trap;
    logic                mfi_halt;

    modport slave (
        input  ret_valid, ret_insn, ret_pc, ret_next_pc, ret_trap, ret_halt,
        output ret_ready,
        output mfi_valid, mfi_order, mfi_insn, mfi_pc_rdata, mfi_pc_wdata,
               mfi_trap, mfi_halt
    );

    modport master (
        output ret_valid, ret_insn, ret_pc, ret_next_pc, ret_trap, ret_halt,
        input  ret_ready,
        input  mfi_valid, mfi_order, mfi_insn, mfi_pc_rdata, mfi_pc_wdata,
               mfi_trap, mfi_halt
    );

endinterface

// File: rtl/mfi_fifo.sv
// Circular packet buffer: up to two pushes and one pop per cycle.
// Storage is not reset; only the pointers and occupancy are.
module mfi_fifo
    import mfi_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [1:0]             push_cnt_i,
    input  mfi_packet_t            push0_i,
    input  mfi_packet_t            push1_i,
    input  logic                   pop_i,
    output mfi_packet_t            head_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] free_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    mfi_packet_t   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          pop_eff;

    assign empty_o = (count_q == '0);
    assign free_o  = CW'(DEPTH) - count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // Pointer and occupancy next-state; pointers wrap because DEPTH is a power of two.
    always_comb begin
        pop_eff  = pop_i && !empty_o;
        wr_ptr_d = wr_ptr_q + AW'(push_cnt_i);
        rd_ptr_d = rd_ptr_q + AW'(pop_eff);
        count_d  = count_q + CW'(push_cnt_i) - CW'(pop_eff);
    end

    // Control state registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Packet storage writes; slot order is preserved by writing push0 first.
    always_ff @(posedge clock) begin
        if (push_cnt_i != 2'd0) begin
            mem_q[wr_ptr_q] <= push0_i;
        end
        if (push_cnt_i == 2'd2) begin
            mem_q[wr_ptr_q + AW'(1)] <= push1_i;
        end
    end

endmodule

// File: rtl/mfi_retire_emitter.sv
// Converts two-wide retire groups into a single-packet-per-cycle MFI stream
// with consecutive order numbers. An empty buffer lets slot 0 bypass
// straight into the output register so the first packet costs one cycle.
module mfi_retire_emitter
    import mfi_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                clock,
    input  logic                reset,
    mfi_retire_emitter_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic               halted_q, halted_d;
    logic [ORDER_W-1:0] next_order_q, next_order_d;
    logic               out_valid_q, out_valid_d;
    mfi_packet_t        out_pkt_q, out_pkt_d;

    logic [CW-1:0]      fifo_free;
    logic               fifo_empty;
    mfi_packet_t        fifo_head;
    logic [1:0]         fifo_push_cnt;
    mfi_packet_t        fifo_push0, fifo_push1;
    logic               fifo_pop;

    logic               ready;
    logic               legal;
    logic               accept;
    logic               take1;
    mfi_packet_t        ent0, ent1;

    assign ready         = !halted_q && (fifo_free >= CW'(2));
    assign bus.ret_ready = ready;

    // Accept decision, order assignment, buffer/bypass routing and output selection.
    always_comb begin
        legal  = (bus.ret_valid == 2'b01) || (bus.ret_valid == 2'b11);
        accept = ready && legal;
        take1  = accept && bus.ret_valid[1] && !bus.ret_halt[0];

        ent0 = mk_packet(next_order_q, bus.ret_insn[31:0], bus.ret_pc[31:0],
                         bus.ret_next_pc[31:0], bus.ret_trap[0], bus.ret_halt[0]);
        ent1 = mk_packet(next_order_q + ORDER_W'(1), bus.ret_insn[63:32],
                         bus.ret_pc[63:32], bus.ret_next_pc[63:32],
                         bus.ret_trap[1], bus.ret_halt[1]);

        next_order_d = next_order_q + ORDER_W'(accept) + ORDER_W'(take1);
        halted_d     = halted_q || (accept && ent0.halt) || (take1 && ent1.halt);

        fifo_pop = !fifo_empty;
        if (fifo_empty) begin
            fifo_push_cnt = {1'b0, take1};
            fifo_push0    = ent1;
        end else begin
            fifo_push_cnt = {1'b0, accept} + {1'b0, take1};
            fifo_push0    = ent0;
        end
        fifo_push1 = ent1;

        out_valid_d = 1'b0;
        out_pkt_d   = '0;
        if (!fifo_empty) begin
            out_valid_d = 1'b1;
            out_pkt_d   = fifo_head;
        end else if (accept) begin
            out_valid_d = 1'b1;
            out_pkt_d   = ent0;
        end
    end

    // Sticky halt, sequence counter and registered MFI outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            halted_q     <= 1'b0;
            next_order_q <= '0;
            out_valid_q  <= 1'b0;
            out_pkt_q    <= '0;
        end else begin
            halted_q     <= halted_d;
            next_order_q <= next_order_d;
            out_valid_q  <= out_valid_d;
            out_pkt_q    <= out_pkt_d;
        end
    end

    mfi_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push_cnt_i (fifo_push_cnt),
        .push0_i    (fifo_push0),
        .push1_i    (fifo_push1),
        .pop_i      (fifo_pop),
        .head_o     (fifo_head),
        .empty_o    (fifo_empty),
        .free_o     (fifo_free)
    );

    assign bus.mfi_valid    = out_valid_q;
    assign bus.mfi_order    = out_pkt_q.order;
    assign bus.mfi_insn     = out_pkt_q.insn;
    assign bus.mfi_pc_rdata = out_pkt_q.pc_rdata;
    assign bus.mfi_pc_wdata = out_pkt_q.pc_wdata;
    assign bus.mfi_trap     = out_pkt_q.trap;
    assign bus.mfi_halt     = out_pkt_q.halt;

endmodule

// File: tb/tb_mfi_retire_emitter.sv
// Bench for mfi_retire_emitter: directed scenarios plus a random phase,
// checked every cycle against a queue-based model of the retire stream.
module tb_mfi_retire_emitter;
    import mfi_pkg::*;

    localparam int DEPTH = 4;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    mfi_retire_emitter_if bus();

    mfi_retire_emitter #(.DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int ntests = 0;
    int nfail  = 0;

    // Model: packets accepted but not yet shown on the MFI port.
    mfi_packet_t pend[$];
    logic [63:0] m_order;
    bit          m_halted;
    bit          m_known;
    bit          exp_valid;
    mfi_packet_t exp_pkt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        ntests++;
        assert (obs === expv)
        else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock cycle: check ready, drive a group, advance the model, check MFI.
    task automatic step(input bit rst, input logic [1:0] v, input logic [1:0] h,
                        input logic [1:0] t);
        bit          mready;
        bit          acc;
        mfi_packet_t p;
        mready = m_known && !m_halted && ((DEPTH - pend.size()) >= 2);
        if (m_known) chk("ret_ready", {63'd0, bus.ret_ready}, {63'd0, mready});

        reset           = rst;
        bus.ret_valid   = v;
        bus.ret_halt    = h;
        bus.ret_trap    = t;
        bus.ret_insn    = {$urandom(), $urandom()};
        bus.ret_pc      = {$urandom(), $urandom()};
        bus.ret_next_pc = {$urandom(), $urandom()};

        if (rst) begin
            pend.delete();
            m_order   = 64'd0;
            m_halted  = 1'b0;
            m_known   = 1'b1;
            exp_valid = 1'b0;
            exp_pkt   = '0;
        end else begin
            acc = mready && (v == 2'b01 || v == 2'b11);
            if (acc) begin
                for (int s = 0; s < 2; s++) begin
                    if (v[s]) begin
                        p.order    = m_order;
                        p.insn     = bus.ret_insn[32*s +: 32];
                        p.pc_rdata = bus.ret_pc[32*s +: 32];
                        p.pc_wdata = bus.ret_next_pc[32*s +: 32];
                        p.trap     = t[s];
                        p.halt     = h[s];
                        pend.push_back(p);
                        m_order++;
                        if (h[s]) begin
                            m_halted = 1'b1;
                            break;
                        end
                    end
                end
            end
            if (pend.size() > 0) begin
                exp_valid = 1'b1;
                exp_pkt   = pend.pop_front();
            end else begin
                exp_valid = 1'b0;
                exp_pkt   = '0;
            end
        end

        @(posedge clock);
        @(negedge clock);

        if (m_known) begin
            chk("mfi_valid", {63'd0, bus.mfi_valid}, {63'd0, exp_valid});
            chk("mfi_order", bus.mfi_order, exp_pkt.order);
            chk("mfi_insn", {32'd0, bus.mfi_insn}, {32'd0, exp_pkt.insn});
            chk("mfi_pc_rdata", {32'd0, bus.mfi_pc_rdata}, {32'd0, exp_pkt.pc_rdata});
            chk("mfi_pc_wdata", {32'd0, bus.mfi_pc_wdata}, {32'd0, exp_pkt.pc_wdata});
            chk("mfi_trap_halt", {62'd0, bus.mfi_trap, bus.mfi_halt},
                {62'd0, exp_pkt.trap, exp_pkt.halt});
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 2'b00, 2'b00, 2'b00);
    endtask

    initial begin
        logic [1:0] rv;
        logic [1:0] rh;
        bit         rr;

        m_known         = 1'b0;
        m_halted        = 1'b0;
        m_order         = 64'd0;
        reset           = 1'b1;
        bus.ret_valid   = 2'b00;
        bus.ret_halt    = 2'b00;
        bus.ret_trap    = 2'b00;
        bus.ret_insn    = '0;
        bus.ret_pc      = '0;
        bus.ret_next_pc = '0;
        @(negedge clock);

        // Reset, with a group presented during reset that must be ignored.
        step(1'b1, 2'b11, 2'b00, 2'b00);
        step(1'b1, 2'b01, 2'b00, 2'b00);

        // Three back-to-back dual retires: orders 0..5, ready drops when full.
        step(1'b0, 2'b11, 2'b00, 2'b01);
        step(1'b0, 2'b11, 2'b00, 2'b10);
        step(1'b0, 2'b11, 2'b00, 2'b00);
        step(1'b0, 2'b11, 2'b00, 2'b00);
        idle(8);

        // Illegal slot-1-only group consumes no order number.
        step(1'b0, 2'b10, 2'b00, 2'b00);
        step(1'b0, 2'b01, 2'b00, 2'b00);
        idle(3);

        // Randomized traffic with occasional halts and resets.
        for (int i = 0; i < 400; i++) begin
            rv = 2'($urandom_range(0, 3));
            rh[0] = ($urandom_range(0, 39) == 0);
            rh[1] = ($urandom_range(0, 39) == 0);
            rr = ($urandom_range(0, 59) == 0);
            step(rr, rv, rh, 2'($urandom_range(0, 3)));
        end

        // Single halt, then a group that must be refused forever.
        step(1'b1, 2'b00, 2'b00, 2'b00);
        step(1'b0, 2'b01, 2'b01, 2'b00);
        step(1'b0, 2'b11, 2'b00, 2'b00);
        idle(6);

        // Halt in slot 0 drops slot 1; reset restarts order at 0.
        step(1'b1, 2'b00, 2'b00, 2'b00);
        step(1'b0, 2'b11, 2'b01, 2'b00);
        idle(4);
        step(1'b1, 2'b00, 2'b00, 2'b00);
        step(1'b0, 2'b01, 2'b00, 2'b00);
        idle(2);

        // Fill the buffer then reset mid-drain.
        step(1'b0, 2'b11, 2'b00, 2'b00);
        step(1'b0, 2'b11, 2'b00, 2'b00);
        step(1'b0, 2'b11, 2'b00, 2'b00);
        step(1'b1, 2'b00, 2'b00, 2'b00);
        step(1'b0, 2'b00, 2'b00, 2'b00);
        step(1'b0, 2'b11, 2'b00, 2'b00);
        idle(4);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
